// File: rtl/cplx_conj_rot.sv
// cplx_conj_rot: streaming I/Q conditioner applying pass / conjugate / negate /
// xj / x-j / IQ-swap, with the operation latched at frame start, optional
// saturation of the most-negative code on negation, and a saturation counter.
// Fixed two-cycle latency from data_en_i to data_en_o.
module cplx_conj_rot #(
    parameter int DATA_SIZE = 16,
    parameter bit SATURATE  = 1'b1,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 data_clk_i,
    input  logic                 data_rst_i,
    input  logic [DATA_SIZE-1:0] data_i_i,
    input  logic [DATA_SIZE-1:0] data_q_i,
    input  logic                 data_en_i,
    input  logic                 data_sof_i,
    input  logic                 data_eof_i,
    input  logic [2:0]           mode_i,
    input  logic                 sat_clr_i,
    output logic [DATA_SIZE-1:0] data_i_o,
    output logic [DATA_SIZE-1:0] data_q_o,
    output logic                 data_en_o,
    output logic                 data_sof_o,
    output logic                 data_eof_o,
    output logic [2:0]           mode_o,
    output logic [CNT_SIZE-1:0]  sat_cnt_o
);

    typedef enum logic {
        IDLE,
        IN_FRAME
    } state_t;

    typedef enum logic [2:0] {
        MODE_PASS = 3'd0,
        MODE_CONJ = 3'd1,
        MODE_NEG  = 3'd2,
        MODE_MULJ = 3'd3,
        MODE_MULNJ = 3'd4,
        MODE_SWAP = 3'd5
    } mode_t;

    localparam logic [DATA_SIZE-1:0] MIN_VAL = {1'b1, {(DATA_SIZE-1){1'b0}}};
    localparam logic [DATA_SIZE-1:0] MAX_VAL = ~MIN_VAL;

    // Returns {sat_flag, value}; only the most-negative code can overflow.
    function automatic logic [DATA_SIZE:0] negate(input logic [DATA_SIZE-1:0] x);
        logic signed [DATA_SIZE:0] wide;
        wide = -$signed({x[DATA_SIZE-1], x});
        if (SATURATE && (x == MIN_VAL))
            negate = {1'b1, MAX_VAL};
        else
            negate = {1'b0, wide[DATA_SIZE-1:0]};
    endfunction

    state_t                 state;
    logic [2:0]             mode_q;
    logic                   latch;
    logic [2:0]             eff_mode;

    logic                   s1_en, s1_sof, s1_eof;
    logic [DATA_SIZE-1:0]   s1_i, s1_q;
    logic [2:0]             s1_mode;

    logic [DATA_SIZE:0]     neg_i, neg_q;
    logic [DATA_SIZE-1:0]   res_i, res_q;
    logic                   res_sat;
    logic                   sat_flag;

    // The latching sample (first after IDLE, or any sof) uses the new mode itself.
    assign latch    = data_en_i && ((state == IDLE) || data_sof_i);
    assign eff_mode = latch ? mode_i : mode_q;
    assign mode_o   = mode_q;

    // Frame FSM: every valid sample moves to IDLE on eof, otherwise IN_FRAME.
    always_ff @(posedge data_clk_i or posedge data_rst_i) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (data_rst_i) begin
            state  <= IDLE;
            mode_q <= 3'd0;
        end else if (data_en_i) begin
            state <= data_eof_i ? IDLE : IN_FRAME;
            if (latch)
                mode_q <= mode_i;
        end
    end

    // Stage 1: capture the sample, its framing and the mode it must use.
    always_ff @(posedge data_clk_i or posedge data_rst_i) begin
        // NOTE: data registers are reset as well, because outputs must read 0 after reset.
        if (data_rst_i) begin
            s1_en   <= 1'b0;
            s1_sof  <= 1'b0;
            s1_eof  <= 1'b0;
            s1_i    <= '0;
            s1_q    <= '0;
            s1_mode <= 3'd0;
        end else begin
            s1_en  <= data_en_i;
            s1_sof <= data_en_i & data_sof_i;
            s1_eof <= data_en_i & data_eof_i;
            if (data_en_i) begin
                s1_i    <= data_i_i;
                s1_q    <= data_q_i;
                s1_mode <= eff_mode;
            end
        end
    end

    assign neg_i = negate(s1_i);
    assign neg_q = negate(s1_q);

    // Select the sign/swap combination; reserved modes fall through to pass.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        res_i   = s1_i;
        res_q   = s1_q;
        res_sat = 1'b0;
        case (mode_t'(s1_mode))
            MODE_CONJ: begin
                res_q   = neg_q[DATA_SIZE-1:0];
                res_sat = neg_q[DATA_SIZE];
            end
            MODE_NEG: begin
                res_i   = neg_i[DATA_SIZE-1:0];
                res_q   = neg_q[DATA_SIZE-1:0];
                res_sat = neg_i[DATA_SIZE] | neg_q[DATA_SIZE];
            end
            MODE_MULJ: begin
                res_i   = neg_q[DATA_SIZE-1:0];
                res_q   = s1_i;
                res_sat = neg_q[DATA_SIZE];
            end
            MODE_MULNJ: begin
                res_i   = s1_q;
                res_q   = neg_i[DATA_SIZE-1:0];
                res_sat = neg_i[DATA_SIZE];
            end
            MODE_SWAP: begin
                res_i = s1_q;
                res_q = s1_i;
            end
            default: ;
        endcase
    end

    // Stage 2: register results; data holds its last valid value while idle.
    always_ff @(posedge data_clk_i or posedge data_rst_i) begin
        if (data_rst_i) begin
            data_en_o  <= 1'b0;
            data_sof_o <= 1'b0;
            data_eof_o <= 1'b0;
            sat_flag   <= 1'b0;
            data_i_o   <= '0;
            data_q_o   <= '0;
        end else begin
            data_en_o  <= s1_en;
            data_sof_o <= s1_sof;
            data_eof_o <= s1_eof;
            sat_flag   <= s1_en & res_sat;
            if (s1_en) begin
                data_i_o <= res_i;
                data_q_o <= res_q;
            end
        end
    end

    // Saturation counter: counts output samples carrying the sat flag, sticky at max, clear wins.
    always_ff @(posedge data_clk_i or posedge data_rst_i) begin
        if (data_rst_i)
            sat_cnt_o <= '0;
        else if (sat_clr_i)
            sat_cnt_o <= '0;
        else if (data_en_o && sat_flag && (sat_cnt_o != {CNT_SIZE{1'b1}}))
            sat_cnt_o <= sat_cnt_o + CNT_SIZE'(1);
    end

endmodule
